// File: rtl/rc4_stream.sv
// RC4 keystream generator: runtime key length, optional drop[n],
// valid/ready output with backpressure. S-box held in registers.
module rc4_stream #(
  parameter int KEY_BYTES_MAX = 16,
  parameter int DROP_N        = 0,
  parameter int LW            = $clog2(KEY_BYTES_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [8*KEY_BYTES_MAX-1:0] key,
  input  logic [LW-1:0]              key_length,
  input  logic                       stop,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic                       busy,
  output logic                       err
);

  localparam int KW = (KEY_BYTES_MAX > 1) ? $clog2(KEY_BYTES_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    DROP,
    GEN
  } state_e;

  state_e        state_q;
  logic [7:0]    i_q;
  logic [7:0]    j_q;
  logic [KW-1:0] kidx_q;
  logic [15:0]   drop_q;
  logic [LW-1:0] len_q;
  logic [7:0]    key_q [KEY_BYTES_MAX];
  logic [7:0]    s_q   [256];
  logic [7:0]    ks_data_q;
  logic          ks_valid_q;
  logic          err_q;

  logic          len_ok;
  logic          adv;
  logic [7:0]    ksi;
  logic [7:0]    kj;
  logic [7:0]    ksj;
  logic [7:0]    pi;
  logic [7:0]    psi;
  logic [7:0]    pj;
  logic [7:0]    psj;
  logic [7:0]    pt;
  logic [7:0]    pout;
  logic          s_init;
  logic          s_we;
  logic [7:0]    wa;
  logic [7:0]    wb;
  logic [7:0]    wva;
  logic [7:0]    wvb;

  assign len_ok = (key_length != '0) &&
                  (key_length <= LW'(KEY_BYTES_MAX));
  assign adv    = !ks_valid_q || ks_ready;

  // KSA datapath: j += S[i] + key[i mod len]
  assign ksi = s_q[i_q];
  assign kj  = j_q + ksi + key_q[kidx_q];
  assign ksj = s_q[kj];

  // PRGA datapath; output byte resolved against the pending swap
  assign pi  = i_q + 8'd1;
  assign psi = s_q[pi];
  assign pj  = j_q + psi;
  assign psj = s_q[pj];
  assign pt  = psi + psj;

  // Select post-swap S[t] without waiting for the write
  always_comb begin
    if (pt == pi) begin
      pout = psj;
    end else if (pt == pj) begin
      pout = psi;
    end else begin
      pout = s_q[pt];
    end
  end

  // S-box write control: init, KSA swap or PRGA swap
  always_comb begin
    s_init = (state_q == INIT);
    s_we   = 1'b0;
    wa     = pi;
    wb     = pj;
    wva    = psj;
    wvb    = psi;
    unique case (state_q)
      KSA: begin
        s_we = 1'b1;
        wa   = i_q;
        wb   = kj;
        wva  = ksj;
        wvb  = ksi;
      end
      DROP: s_we = 1'b1;
      GEN:  s_we = adv;
      default: s_we = 1'b0;
    endcase
  end

  // S-box storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (s_init) begin
      for (int k = 0; k < 256; k++) begin
        s_q[k] <= 8'(k);
      end
    end else if (s_we) begin
      s_q[wa] <= wva;
      s_q[wb] <= wvb;
    end
  end

  // Session FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      drop_q     <= '0;
      len_q      <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < KEY_BYTES_MAX; k++) begin
        key_q[k] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      if (stop) begin
        state_q    <= IDLE;
        ks_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              if (len_ok) begin
                len_q   <= key_length;
                state_q <= INIT;
                for (int k = 0; k < KEY_BYTES_MAX; k++) begin
                  key_q[k] <= key[8*k +: 8];
                end
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          INIT: begin
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            state_q <= KSA;
          end
          KSA: begin
            j_q <= kj;
            i_q <= i_q + 8'd1;
            if (LW'(kidx_q) == len_q - LW'(1)) begin
              kidx_q <= '0;
            end else begin
              kidx_q <= kidx_q + KW'(1);
            end
            if (i_q == 8'd255) begin
              i_q     <= '0;
              j_q     <= '0;
              drop_q  <= '0;
              state_q <= (DROP_N > 0) ? DROP : GEN;
            end
          end
          DROP: begin
            i_q    <= pi;
            j_q    <= pj;
            drop_q <= drop_q + 16'd1;
            if (drop_q == 16'(DROP_N - 1)) begin
              state_q <= GEN;
            end
          end
          GEN: begin
            if (start && len_ok) begin
              len_q      <= key_length;
              ks_valid_q <= 1'b0;
              state_q    <= INIT;
              for (int k = 0; k < KEY_BYTES_MAX; k++) begin
                key_q[k] <= key[8*k +: 8];
              end
            end else begin
              if (start) begin
                err_q <= 1'b1;
              end
              if (adv) begin
                i_q        <= pi;
                j_q        <= pj;
                ks_data_q  <= pout;
                ks_valid_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ks_data  = ks_data_q;
  assign ks_valid = ks_valid_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_rc4_stream.sv
// Directed bench for rc4_stream: known RC4 vectors, drop[2],
// backpressure, length rejection, stop and async reset.
module tb_rc4_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [4:0]   key_length;
  logic         stop;
  logic [7:0]   ks_data;
  logic         ks_valid;
  logic         ks_ready;
  logic         busy;
  logic         err;
  logic [7:0]   ks_data2;
  logic         ks_valid2;
  logic         busy2;
  logic         err2;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] K_KEY  = 128'h79654B;
  localparam logic [127:0] K_WIKI = 128'h696B6957;

  always #5 clk = ~clk;

  rc4_stream #(.KEY_BYTES_MAX(16), .DROP_N(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .key_length(key_length),
    .stop      (stop),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .busy      (busy),
    .err       (err)
  );

  rc4_stream #(.KEY_BYTES_MAX(16), .DROP_N(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .key_length(key_length),
    .stop      (stop),
    .ks_data   (ks_data2),
    .ks_valid  (ks_valid2),
    .ks_ready  (1'b1),
    .busy      (busy2),
    .err       (err2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge; the key bus is scrambled afterwards
  task automatic kick(input logic [127:0] k, input logic [4:0] len);
    @(posedge clk); #1;
    key        = k;
    key_length = len;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key   = '1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!ks_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!ks_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    int          cyc;
    int          f0;
    int          f2;
    logic [7:0]  q0 [$];
    logic [7:0]  q2 [$];
    logic [7:0]  exp_key [4];
    logic [7:0]  exp_wiki [5];

    exp_key  = '{8'hEB, 8'h9F, 8'h77, 8'h81};
    exp_wiki = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};

    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    key        = '0;
    key_length = '0;
    ks_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", ks_data, 0);
    check("rst_valid", ks_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    step();

    // "Key" on both instances: latency and first bytes
    kick(K_KEY, 5'd3);
    f0 = 0;
    f2 = 0;
    for (int c = 1; c <= 262; c++) begin
      step();
      if (ks_valid && f0 == 0) f0 = c;
      if (ks_valid2 && f2 == 0) f2 = c;
      if (ks_valid) q0.push_back(ks_data);
      if (ks_valid2) q2.push_back(ks_data2);
    end
    check("key_latency", f0, 258);
    check("drop_latency", f2, 260);
    check("key_nbytes", q0.size(), 5);
    for (int n = 0; n < 4; n++) begin
      if (n < q0.size()) check($sformatf("key_b%0d", n), q0[n], exp_key[n]);
    end
    check("drop_nbytes", q2.size(), 3);
    if (q2.size() >= 2) begin
      check("drop_b0", q2[0], 8'h77);
      check("drop_b1", q2[1], 8'h81);
    end

    // "Wiki" rekey from GEN, one byte per cycle
    kick(K_WIKI, 5'd4);
    check("rekey_valid_drop", ks_valid, 0);
    wait_valid(cyc);
    check("wiki_latency", cyc, 258);
    for (int n = 0; n < 5; n++) begin
      check($sformatf("wiki_b%0d", n), ks_data, exp_wiki[n]);
      check($sformatf("wiki_v%0d", n), ks_valid, 1);
      check($sformatf("wiki_busy%0d", n), busy, 1);
      step();
    end

    // Backpressure holds the first byte
    kick(K_KEY, 5'd3);
    wait_valid(cyc);
    check("bp_first", ks_data, 8'hEB);
    ks_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      check($sformatf("bp_hold%0d", n), ks_data, 8'hEB);
      check($sformatf("bp_hv%0d", n), ks_valid, 1);
    end
    ks_ready = 1'b1;
    for (int n = 1; n < 4; n++) begin
      step();
      check($sformatf("bp_b%0d", n), ks_data, exp_key[n]);
    end

    // stop from GEN
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_valid", ks_valid, 0);

    // Rejected lengths
    kick(K_KEY, 5'd0);
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", ks_valid, 0);
    step();
    check("len0_err_clr", err, 0);
    kick(K_KEY, 5'd17);
    check("len17_err", err, 1);
    check("len17_busy", busy, 0);
    check("len17_valid", ks_valid, 0);
    step();
    check("len17_err_clr", err, 0);
    check("len17_busy2", busy, 0);

    // Abort during KSA, then restart
    kick(K_KEY, 5'd3);
    repeat (99) step();
    check("abort_busy_pre", busy, 1);
    check("ksa_no_err", err, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", ks_valid, 0);
    kick(K_KEY, 5'd3);
    wait_valid(cyc);
    check("restart_latency", cyc, 258);
    check("restart_b0", ks_data, 8'hEB);
    repeat (3) step();

    // Asynchronous reset mid-GEN
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", ks_data, 0);
    check("arst_valid", ks_valid, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    kick(K_KEY, 5'd3);
    wait_valid(cyc);
    check("post_rst_b0", ks_data, 8'hEB);
    step();
    check("post_rst_b1", ks_data, 8'h9F);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
